// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instructions from an instruction memory and issues
// them one at a time to the instruction decoder. For multi-cycle operations it
// waits for op_done before the next fetch. END_CHAIN retires the program and an
// illegal opcode aborts it with a sticky error flag.
module instr_sequencer #(
  parameter int INSTR_WIDTH = 28,
  parameter int IMEM_AWIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [IMEM_AWIDTH-1:0] start_addr,
  output logic                   imem_rd_en,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  input  logic                   op_done,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  localparam logic [3:0] OP_END_CHAIN = 4'd12;
  localparam logic [INSTR_WIDTH-1:0] INSTR_RESET = {OP_END_CHAIN, {(INSTR_WIDTH-4){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEMWAIT,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IMEM_AWIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   error_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [3:0]             opcode;

  assign opcode = instr_q[INSTR_WIDTH-1 -: 4];

  // Opcodes 13..15 have no decoder meaning and abort the program.
  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'd13;
  endfunction

  // Datapath operations that complete asynchronously and report via op_done.
  function automatic logic is_multi(input logic [3:0] op);
    return (op == 4'd4) || (op == 4'd5) || (op == 4'd6) || (op == 4'd8) ||
           (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
  endfunction

  // Issue counter increments but sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = S_MEMWAIT;
      S_MEMWAIT:   state_nxt = S_DECODE;
      S_DECODE:    state_nxt = is_illegal(opcode) ? S_IDLE : S_ISSUE;
      S_ISSUE: begin
        if (opcode == OP_END_CHAIN) state_nxt = S_FINISH;
        else if (is_multi(opcode))  state_nxt = S_WAIT_DONE;
        else                        state_nxt = S_FETCH;
      end
      S_WAIT_DONE: if (op_done) state_nxt = S_FETCH;
      S_FINISH:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Program counter: loaded on start, advanced after single-cycle issue or op_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc <= '0;
    end else begin
      if (state == S_IDLE && start)
        pc <= start_addr;
      else if (state == S_ISSUE && opcode != OP_END_CHAIN && !is_multi(opcode))
        pc <= pc + 1'b1;
      else if (state == S_WAIT_DONE && op_done)
        pc <= pc + 1'b1;
    end
  end

  // Instruction register: captures memory read data only in MEMWAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                instr_q <= INSTR_RESET;
    else if (state == S_MEMWAIT) instr_q <= imem_rdata;
  end

  // Sticky error and saturating issue counter, both cleared by an accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        error_q <= 1'b0;
        cnt_q   <= '0;
      end else if (state == S_DECODE && is_illegal(opcode)) begin
        error_q <= 1'b1;
      end else if (state == S_ISSUE) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  assign imem_rd_en  = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign instr_valid = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FINISH);
  assign error       = error_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and random programs checked cycle by
// cycle against an event-timeline reference model of the sequencer.
module tb_instr_sequencer;

  localparam int IW   = 28;
  localparam int AW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int MAXC = 1024;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          op_done;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  logic [IW-1:0] mem [256];

  // expected per-cycle timeline, cycle 0 = the cycle start is sampled
  bit            e_rd   [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  bit            e_iv   [MAXC];
  logic [IW-1:0] e_ins  [MAXC];
  bit            e_done [MAXC];
  bit            e_busy [MAXC];
  bit            e_err  [MAXC];
  bit            e_wait [MAXC];
  bit            e_opd  [MAXC];
  int            e_cnt  [MAXC];
  int            end_cyc;
  logic [IW-1:0] last_word;
  int            dly_q [$];

  instr_sequencer #(.INSTR_WIDTH(IW), .IMEM_AWIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .start_addr(start_addr),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .op_done(op_done),
    .busy(busy), .done(done), .error(error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory; garbage on the bus when not reading
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
    else            imem_rdata <= IW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
    return op inside {4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  task automatic set_word(input logic [AW-1:0] a, input logic [3:0] op);
    mem[a] = {op, 24'($urandom)};
  endtask

  // Timeline model: a fetch follows the previous step by one cycle, the issue
  // lands three cycles after the fetch, multi-cycle ops resume one cycle after
  // the op_done cycle, END_CHAIN gives done one cycle later and idle two later.
  function automatic void model(input logic [AW-1:0] sa);
    logic [AW-1:0] pc;
    logic [IW-1:0] w;
    logic [3:0]    op;
    int t, f, i, d, di, err_from, cnt;
    bit inc [MAXC];
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_addr[c] = '0; e_iv[c] = 0; e_ins[c] = '0; e_done[c] = 0;
      e_busy[c] = 0; e_err[c] = 0; e_wait[c] = 0; e_opd[c] = 0; e_cnt[c] = 0; inc[c] = 0;
    end
    pc = sa; t = 0; di = 0; err_from = MAXC; end_cyc = 0;
    for (int n = 0; n < 64; n++) begin
      f = t + 1;
      e_rd[f] = 1; e_addr[f] = pc;
      w = mem[pc]; op = w[IW-1 -: 4]; last_word = w;
      if (op >= 4'd13) begin err_from = f + 3; end_cyc = f + 3; break; end
      i = f + 3;
      e_iv[i] = 1; e_ins[i] = w; inc[i+1] = 1;
      if (op == 4'd12) begin e_done[i+1] = 1; end_cyc = i + 2; break; end
      if (is_multi(op)) begin
        d = dly_q[di]; di++;
        for (int k = i + 1; k <= i + d; k++) e_wait[k] = 1;
        e_opd[i+d] = 1;
        t = i + d;
      end else begin
        t = i;
      end
      pc = pc + 1'b1;
    end
    cnt = 0;
    for (int c = 1; c <= end_cyc; c++) begin
      if (inc[c] && cnt < CMAX) cnt++;
      e_cnt[c]  = cnt;
      e_busy[c] = (c < end_cyc);
      e_err[c]  = (c >= err_from);
    end
  endfunction

  // Start a program and check every cycle; stop_at > 0 cuts the run short.
  task automatic run_prog(input logic [AW-1:0] sa, input int stop_at);
    int last;
    model(sa);
    last = (stop_at > 0) ? stop_at : end_cyc;
    @(negedge clk);
    start = 1'b1; start_addr = sa; op_done = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0; op_done = 1'b0;
      chk($sformatf("rd_en@%0d", c), 32'(imem_rd_en), 32'(e_rd[c]));
      if (e_rd[c]) chk($sformatf("addr@%0d", c), 32'(imem_addr), 32'(e_addr[c]));
      chk($sformatf("valid@%0d", c), 32'(instr_valid), 32'(e_iv[c]));
      if (e_iv[c]) chk($sformatf("instr@%0d", c), 32'(instruction), 32'(e_ins[c]));
      chk($sformatf("done@%0d", c), 32'(done), 32'(e_done[c]));
      chk($sformatf("busy@%0d", c), 32'(busy), 32'(e_busy[c]));
      chk($sformatf("error@%0d", c), 32'(error), 32'(e_err[c]));
      chk($sformatf("count@%0d", c), 32'(instr_count), 32'(e_cnt[c]));
      if (e_opd[c]) op_done = 1'b1;
      else if (!e_wait[c] && $urandom_range(0, 3) == 0) op_done = 1'b1;
      if (c < end_cyc && $urandom_range(0, 5) == 0) begin
        start = 1'b1; start_addr = AW'($urandom);
      end
    end
    if (stop_at == 0) chk("instr_hold", 32'(instruction), 32'(last_word));
  endtask

  initial begin
    int len;
    logic [AW-1:0] sa;
    logic [3:0] op;
    resetn = 1'b0; start = 1'b0; start_addr = '0; op_done = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = IW'($urandom);

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(imem_rd_en), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_instr", 32'(instruction), 32'({4'd12, 24'd0}));
    chk("rst_count", 32'(instr_count), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // V_WR, M_WR, END_CHAIN at 0x10
    dly_q.delete();
    set_word(8'h10, 4'd1); set_word(8'h11, 4'd3); set_word(8'h12, 4'd12);
    run_prog(8'h10, 0);
    chk("tp1_end", 32'(end_cyc), 14);
    chk("tp1_count", 32'(instr_count), 3);
    chk("tp1_error", 32'(error), 0);

    // MV_MUL then END_CHAIN, op_done 7 cycles after the issue
    dly_q.delete(); dly_q.push_back(7);
    set_word(8'h20, 4'd4); set_word(8'h21, 4'd12);
    run_prog(8'h20, 0);

    // illegal opcode 14 at the second address
    dly_q.delete();
    set_word(8'h30, 4'd1); set_word(8'h31, 4'd14);
    run_prog(8'h30, 0);
    chk("illegal_error", 32'(error), 1);
    chk("illegal_count", 32'(instr_count), 1);

    // new start after the error clears error and count (checked at cycle 1)
    set_word(8'h10, 4'd1); set_word(8'h11, 4'd3); set_word(8'h12, 4'd12);
    run_prog(8'h10, 0);

    // address wrap 0xFF -> 0x00
    set_word(8'hFF, 4'd0); set_word(8'h00, 4'd12);
    run_prog(8'hFF, 0);

    // counter saturation: 18 single-cycle ops then END_CHAIN
    for (int k = 0; k < 18; k++) set_word(AW'(8'h40 + k), 4'd7);
    set_word(8'h52, 4'd12);
    run_prog(8'h40, 0);
    chk("sat_count", 32'(instr_count), CMAX);

    // start during WAIT_DONE is ignored, then reset mid-WAIT_DONE
    dly_q.delete(); dly_q.push_back(50);
    set_word(8'h60, 4'd8); set_word(8'h61, 4'd12);
    run_prog(8'h60, 12);
    @(negedge clk);
    start = 1'b1; start_addr = 8'h99; op_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("wait_busy", 32'(busy), 1);
    chk("wait_rd_en", 32'(imem_rd_en), 0);
    chk("wait_addr", 32'(imem_addr), 32'h60);
    chk("wait_count", 32'(instr_count), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_rd_en", 32'(imem_rd_en), 0);
    chk("arst_addr", 32'(imem_addr), 0);
    chk("arst_error", 32'(error), 0);
    chk("arst_count", 32'(instr_count), 0);
    chk("arst_instr", 32'(instruction), 32'({4'd12, 24'd0}));
    @(posedge clk); #1;
    chk("arst_hold_busy", 32'(busy), 0);
    chk("arst_hold_done", 32'(done), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // random programs
    for (int r = 0; r < 12; r++) begin
      dly_q.delete();
      sa  = AW'($urandom);
      len = $urandom_range(0, 6);
      for (int k = 0; k < len; k++) begin
        op = 4'($urandom_range(0, 11));
        set_word(AW'(sa + k), op);
        if (is_multi(op)) dly_q.push_back($urandom_range(1, 9));
      end
      if ($urandom_range(0, 3) == 0) set_word(AW'(sa + len), 4'($urandom_range(13, 15)));
      else                           set_word(AW'(sa + len), 4'd12);
      run_prog(sa, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
